// File: rtl/fila_pedidos_serial.sv
// fila_pedidos_serial: validates command bytes from the serial receiver,
// queues valid requests (normal at the tail, priority at the head) and
// presents them one at a time to the request controller with a strobe,
// waiting for an acknowledge before presenting the next one.
module fila_pedidos_serial #(
  parameter int PROF      = 4,
  parameter int LARG_DESC = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      pronto_serial_recebido,
  input  logic [7:0]                dados_serial_recebido,
  input  logic                      pedido_aceito,
  output logic [1:0]                origem,
  output logic [1:0]                destino,
  output logic                      prioritario,
  output logic                      novo_pedido,
  output logic                      vazio,
  output logic                      cheio,
  output logic [$clog2(PROF):0]     ocupacao,
  output logic [LARG_DESC-1:0]      descartes,
  output logic [1:0]                db_estado
);

  localparam int AW = $clog2(PROF);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0]        PROF_C   = CW'(PROF);
  localparam logic [CW-1:0]        UM_C     = CW'(1);
  localparam logic [AW-1:0]        UM_P     = AW'(1);
  localparam logic [LARG_DESC-1:0] UM_D     = LARG_DESC'(1);
  localparam logic [LARG_DESC-1:0] DESC_MAX = '1;

  typedef enum logic [1:0] {
    ESPERA  = 2'b00,
    EMITE   = 2'b01,
    AGUARDA = 2'b10
  } estado_t;

  typedef struct packed {
    logic       prio;
    logic [1:0] dest;
    logic [1:0] orig;
  } entrada_t;

  // Registered state
  logic                 pronto_ant_q, pronto_ant_d;
  entrada_t             mem_q [PROF];
  entrada_t             mem_d [PROF];
  logic [AW-1:0]        rd_q, rd_d;
  logic [AW-1:0]        wr_q, wr_d;
  logic [CW-1:0]        cont_q, cont_d;
  logic                 vazio_q, vazio_d;
  logic                 cheio_q, cheio_d;
  logic [LARG_DESC-1:0] descartes_q, descartes_d;
  estado_t              estado_q, estado_d;
  logic [1:0]           origem_q, origem_d;
  logic [1:0]           destino_q, destino_d;
  logic                 prio_q, prio_d;
  logic                 novo_q, novo_d;

  // Decoded byte and FIFO control
  logic       byte_stb;
  logic [1:0] tipo;
  logic       reservado_ok;
  logic       eh_cancel;
  logic       eh_pedido;
  logic       rejeita;
  logic       pop;
  logic       aceita;
  logic       descarta;
  logic       push_cauda;
  logic       push_cabeca;
  entrada_t   nova;
  entrada_t   cabeca;
  logic [AW-1:0] rd_menos_um;

  // Byte decode: a byte is taken only on the rising edge of the ready flag,
  // so a ready line held high contributes exactly one byte.
  always_comb begin
    byte_stb     = pronto_serial_recebido & ~pronto_ant_q;
    tipo         = dados_serial_recebido[5:4];
    reservado_ok = (dados_serial_recebido[7:6] == 2'b00);
    nova.orig    = dados_serial_recebido[1:0];
    nova.dest    = dados_serial_recebido[3:2];
    nova.prio    = (tipo == 2'b10);
    eh_cancel    = byte_stb & reservado_ok & (tipo == 2'b11);
    eh_pedido    = byte_stb & reservado_ok &
                   ((tipo == 2'b01) | (tipo == 2'b10)) &
                   (nova.orig != nova.dest);
    rejeita      = byte_stb & ~eh_cancel & ~eh_pedido;
    // The emitter pops whenever it is idle and something is stored; a pop
    // frees a slot in the same cycle, so a push into a full FIFO is kept.
    pop          = (estado_q == ESPERA) & (cont_q != '0);
    aceita       = eh_pedido & ((cont_q != PROF_C) | pop);
    descarta     = rejeita | (eh_pedido & ~aceita);
    push_cauda   = aceita & ~nova.prio;
    push_cabeca  = aceita & nova.prio;
    cabeca       = mem_q[rd_q];
    rd_menos_um  = rd_q - UM_P;
  end

  // FIFO next state: circular buffer that accepts pushes at either end.
  always_comb begin
    mem_d  = mem_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cont_d = cont_q;
    if (eh_cancel) begin
      // Flush; a head popped this cycle has already been read by the emitter.
      rd_d   = rd_q;
      wr_d   = rd_q;
      cont_d = '0;
    end else if (push_cabeca && pop) begin
      // The popped head slot is reused so the new entry becomes the head.
      mem_d[rd_q] = nova;
    end else if (push_cabeca) begin
      mem_d[rd_menos_um] = nova;
      rd_d   = rd_menos_um;
      cont_d = cont_q + UM_C;
    end else if (push_cauda && pop) begin
      mem_d[wr_q] = nova;
      wr_d = wr_q + UM_P;
      rd_d = rd_q + UM_P;
    end else if (push_cauda) begin
      mem_d[wr_q] = nova;
      wr_d   = wr_q + UM_P;
      cont_d = cont_q + UM_C;
    end else if (pop) begin
      rd_d   = rd_q + UM_P;
      cont_d = cont_q - UM_C;
    end
  end

  // Status flags and saturating discard counter next state.
  always_comb begin
    pronto_ant_d = pronto_serial_recebido;
    vazio_d      = (cont_d == '0);
    cheio_d      = (cont_d == PROF_C);
    descartes_d  = descartes_q;
    if (descarta && (descartes_q != DESC_MAX)) begin
      descartes_d = descartes_q + UM_D;
    end
  end

  // Emitter FSM next state and registered request outputs.
  always_comb begin
    estado_d  = estado_q;
    origem_d  = origem_q;
    destino_d = destino_q;
    prio_d    = prio_q;
    novo_d    = 1'b0;
    unique case (estado_q)
      ESPERA: begin
        if (cont_q != '0) begin
          estado_d  = EMITE;
          origem_d  = cabeca.orig;
          destino_d = cabeca.dest;
          prio_d    = cabeca.prio;
          novo_d    = 1'b1;
        end
      end
      EMITE: begin
        estado_d = AGUARDA;
      end
      AGUARDA: begin
        if (pedido_aceito) begin
          estado_d = ESPERA;
        end
      end
      default: begin
        estado_d = ESPERA;
      end
    endcase
  end

  // State registers; reset drops any stored or pending request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pronto_ant_q <= 1'b0;
      for (int i = 0; i < PROF; i++) begin
        mem_q[i] <= '0;
      end
      rd_q        <= '0;
      wr_q        <= '0;
      cont_q      <= '0;
      vazio_q     <= 1'b1;
      cheio_q     <= 1'b0;
      descartes_q <= '0;
      estado_q    <= ESPERA;
      origem_q    <= 2'b00;
      destino_q   <= 2'b00;
      prio_q      <= 1'b0;
      novo_q      <= 1'b0;
    end else begin
      pronto_ant_q <= pronto_ant_d;
      mem_q        <= mem_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      cont_q       <= cont_d;
      vazio_q      <= vazio_d;
      cheio_q      <= cheio_d;
      descartes_q  <= descartes_d;
      estado_q     <= estado_d;
      origem_q     <= origem_d;
      destino_q    <= destino_d;
      prio_q       <= prio_d;
      novo_q       <= novo_d;
    end
  end

  assign origem      = origem_q;
  assign destino     = destino_q;
  assign prioritario = prio_q;
  assign novo_pedido = novo_q;
  assign vazio       = vazio_q;
  assign cheio       = cheio_q;
  assign ocupacao    = cont_q;
  assign descartes   = descartes_q;
  assign db_estado   = estado_q;

endmodule

// File: doc/fila_pedidos_serial.md
# fila_pedidos_serial

Request queue and validator between the 8N1 serial receiver and the new-request path of the cargo elevator datapath. It takes each received command byte, checks it, and stores valid ones in a small FIFO. Stored requests are presented one at a time as origin/destination floor codes with a single-cycle `novo_pedido` strobe. It waits for the request controller to acknowledge each one before presenting the next, so no request is lost while the elevator is busy.

## Interface
- `PROF`, 4: FIFO depth in entries; power of two, 2..16.
- `LARG_DESC`, 4: width of the saturating discard counter.

- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `pronto_serial_recebido`  in  1  byte-ready from the serial receiver; a byte is taken on each rising edge only (held high means one byte).
- `dados_serial_recebido`  in  8  received byte, valid while `pronto_serial_recebido`=1.
- `pedido_aceito`  in  1  acknowledge from the request controller; frees the emitter.
- `origem`  out  2  origin floor of the presented request (registered).
- `destino`  out  2  destination floor of the presented request (registered).
- `prioritario`  out  1  presented request was a priority request.
- `novo_pedido`  out  1  one-cycle strobe when `origem`/`destino` take a new request.
- `vazio`  out  1  FIFO empty.
- `cheio`  out  1  FIFO holds `PROF` entries.
- `ocupacao`  out  $clog2(PROF)+1  current entry count.
- `descartes`  out  LARG_DESC  saturating count of rejected or dropped bytes.
- `db_estado`  out  2  emitter state encoding, for debug display.

## Operation
- Byte format: [1:0] origin, [3:2] destination, [5:4] type, [7:6] reserved and must be 00.
- Type 01 = normal: the request is written at the FIFO tail.
- Type 10 = priority: the request is written at the FIFO head, ahead of all stored entries. FIFO entries carry a priority flag for this.
- Type 11 = cancel: flushes every stored entry. A request already presented is not affected. The cancel byte itself is never queued.
- Rejected bytes (each increments `descartes`): type 00; reserved bits nonzero; origin == destination for type 01/10.
- Dropped bytes (each increments `descartes`): a valid type 01/10 byte arriving when the FIFO is full, unless a pop occurs in the same cycle. In that case the byte is accepted.
- `descartes` saturates at all-ones.
- Emitter FSM:
  - ESPERA (00): when `vazio`=0, go to EMITE. On that edge the head entry loads into `origem`/`destino`/`prioritario` and is popped.
  - EMITE (01): `novo_pedido`=1 for exactly this cycle; go to AGUARDA unconditionally.
  - AGUARDA (10): hold the outputs; on the edge where `pedido_aceito`=1, go to ESPERA.
  - `pedido_aceito` outside AGUARDA is ignored.
- Simultaneous events:
  - Pop and cancel in the same cycle: the popped entry is still emitted; the FIFO ends empty.
  - Pop and priority push in the same cycle: the pushed entry becomes the new head.
  - Pop and normal push when full: both take effect; `ocupacao` is unchanged.
  - Cancel with an empty FIFO: no effect beyond the flush.
- Reset mid-operation: the FIFO empties, the FSM returns to ESPERA, and a pending strobe or request is lost.

## Timing
- Reset values:
  - `origem`=0, `destino`=0, `prioritario`=0, `novo_pedido`=0;
  - `vazio`=1, `cheio`=0, `ocupacao`=0;
  - `descartes`=0, `db_estado`=00.
- The byte is sampled on the edge ending the cycle in which the `pronto_serial_recebido` rising edge is detected (cycle N); `ocupacao` updates after that edge.
- With an empty FIFO and the FSM in ESPERA: the FSM moves to EMITE at the end of cycle N+1, and `novo_pedido` is high during cycle N+2. Latency is 2 cycles.
- Minimum spacing between `novo_pedido` strobes is 3 cycles (ESPERA→EMITE→AGUARDA with `pedido_aceito` high in the first AGUARDA cycle).
- `vazio`, `cheio` and `ocupacao` are registered and reflect the state after the last edge.

## Test plan
- Reset, then byte 0x14 (type 01, origin 0, destination 1) -> 2 cycles later `novo_pedido` pulses once with `origem`=0, `destino`=1, `prioritario`=0, `ocupacao` back to 0; FSM in AGUARDA until `pedido_aceito`.
- Without acking, send normal bytes 0x1B, 0x12, 0x16, 0x19, 0x1E -> four entries queued, `cheio`=1, fifth byte dropped, `descartes`=1; acking drains the entries in arrival order with one strobe per ack.
- Queue 0x1B and 0x12, then send priority byte 0x23 -> the next emitted request is origin 3, destination 0, `prioritario`=1, followed by 0x1B then 0x12.
- Queue two entries, send 0x30 (cancel) -> `vazio`=1, `ocupacao`=0; the request already presented stays on `origem`/`destino`; no further strobes after the ack.
- Send invalid bytes 0x00, 0x15 (origin = destination = 1) and 0x94 (reserved bits set) -> no queue change, `descartes`=3; after 20 rejections `descartes` holds at 15.
- Hold `pronto_serial_recebido` high for 5 cycles with 0x14 -> exactly one entry queued. Assert `reset` during AGUARDA with 2 entries queued -> all outputs at reset values immediately.
